// File: rtl/noc_pkg.sv
// Shared NoC router definitions: flit type codes, output-port indices and the
// input-channel controller state encoding.
package noc_pkg;

    localparam int unsigned FLIT_TYPE_W = 2;

    localparam logic [FLIT_TYPE_W-1:0] FLIT_BODY   = 2'b00;
    localparam logic [FLIT_TYPE_W-1:0] FLIT_HEAD   = 2'b01;
    localparam logic [FLIT_TYPE_W-1:0] FLIT_TAIL   = 2'b10;
    localparam logic [FLIT_TYPE_W-1:0] FLIT_SINGLE = 2'b11;

    localparam int unsigned PORT_L    = 0;
    localparam int unsigned PORT_N    = 1;
    localparam int unsigned PORT_E    = 2;
    localparam int unsigned PORT_S    = 3;
    localparam int unsigned PORT_W    = 4;
    localparam int unsigned NUM_PORTS = 5;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_ACTIVE = 2'd2
    } route_state_e;

    // Flit opens a packet (carries a destination)
    function automatic logic flit_is_head(input logic [FLIT_TYPE_W-1:0] t);
        return (t == FLIT_HEAD) || (t == FLIT_SINGLE);
    endfunction

    // Flit closes a packet
    function automatic logic flit_is_tail(input logic [FLIT_TYPE_W-1:0] t);
        return (t == FLIT_TAIL) || (t == FLIT_SINGLE);
    endfunction

endpackage

// File: rtl/xy_route_calc.sv
// Dimension-ordered (X then Y) route computation; one-hot {W,S,E,N,L} result.
module xy_route_calc
    import noc_pkg::*;
#(
    parameter int unsigned COORD_W = 2
) (
    input  logic [COORD_W-1:0]   dst_x_i,
    input  logic [COORD_W-1:0]   dst_y_i,
    input  logic [COORD_W-1:0]   cur_x_i,
    input  logic [COORD_W-1:0]   cur_y_i,
    output logic [NUM_PORTS-1:0] route_o
);

    // Resolve X first, then Y, else deliver locally
    always_comb begin
        route_o = '0;
        if (dst_x_i > cur_x_i) begin
            route_o[PORT_E] = 1'b1;
        end else if (dst_x_i < cur_x_i) begin
            route_o[PORT_W] = 1'b1;
        end else if (dst_y_i > cur_y_i) begin
            route_o[PORT_N] = 1'b1;
        end else if (dst_y_i < cur_y_i) begin
            route_o[PORT_S] = 1'b1;
        end else begin
            route_o[PORT_L] = 1'b1;
        end
    end

endmodule

// File: rtl/input_route_ctrl.sv
// Input-channel controller: routes head flits, requests the output port and
// streams the packet to the crossbar once granted.
// Optional feature macro: ROUTE_PKT_COUNT_EN (completed-packet counter).
module input_route_ctrl
    import noc_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned COORD_W    = 2,
    parameter int unsigned CUR_X      = 0,
    parameter int unsigned CUR_Y      = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    input  logic                  fifo_empty,
    output logic                  fifo_read,
    output logic [NUM_PORTS-1:0]  route_req,
    input  logic                  route_gnt,
    output logic [DATA_WIDTH-1:0] flit_out,
    output logic                  flit_valid,
    input  logic                  flit_ready,
    output logic                  drop_err,
    output logic [15:0]           pkt_count
);

    route_state_e          state_q, state_d;
    logic [NUM_PORTS-1:0]  route_req_q, route_req_d;
    logic                  drop_err_q, drop_err_d;
    logic [FLIT_TYPE_W-1:0] flit_type;
    logic [NUM_PORTS-1:0]  route_calc;
    logic                  pkt_done;

    assign flit_type = fifo_data[DATA_WIDTH-1 -: FLIT_TYPE_W];
    assign flit_out  = fifo_data;
    assign route_req = route_req_q;
    assign drop_err  = drop_err_q;

    xy_route_calc #(
        .COORD_W (COORD_W)
    ) u_xy_route_calc (
        .dst_x_i (fifo_data[2*COORD_W-1 -: COORD_W]),
        .dst_y_i (fifo_data[COORD_W-1:0]),
        .cur_x_i (COORD_W'(CUR_X)),
        .cur_y_i (COORD_W'(CUR_Y)),
        .route_o (route_calc)
    );

    // Next-state and handshake decode; nothing is popped while in reset
    always_comb begin
        state_d     = state_q;
        route_req_d = route_req_q;
        drop_err_d  = 1'b0;
        fifo_read   = 1'b0;
        flit_valid  = 1'b0;
        pkt_done    = 1'b0;
        if (!rst) begin
            case (state_q)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        if (flit_is_head(flit_type)) begin
                            route_req_d = route_calc;
                            state_d     = ST_REQ;
                        end else begin
                            // Orphan body/tail: discard and flag
                            fifo_read  = 1'b1;
                            drop_err_d = 1'b1;
                        end
                    end
                end
                ST_REQ: begin
                    if (route_gnt) begin
                        state_d = ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    flit_valid = !fifo_empty;
                    fifo_read  = flit_valid & flit_ready;
                    if (fifo_read && flit_is_tail(flit_type)) begin
                        pkt_done    = 1'b1;
                        route_req_d = '0;
                        state_d     = ST_IDLE;
                    end
                end
                default: begin
                    route_req_d = '0;
                    state_d     = ST_IDLE;
                end
            endcase
        end
    end

    // State, request and error-pulse registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            route_req_q <= '0;
            drop_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            route_req_q <= route_req_d;
            drop_err_q  <= drop_err_d;
        end
    end

`ifdef ROUTE_PKT_COUNT_EN
    localparam int unsigned CNT_W = 16;
    logic [CNT_W-1:0] pkt_count_q;

    // Completed-packet counter, wraps naturally
    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_count_q <= '0;
        end else if (pkt_done) begin
            pkt_count_q <= pkt_count_q + CNT_W'(1);
        end
    end

    assign pkt_count = pkt_count_q;
`else
    logic unused_pkt_done;
    assign unused_pkt_done = pkt_done;
    assign pkt_count       = 16'd0;
`endif

endmodule
